// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the counter_ctrl timer
//
// Purpose : state encoding, mode encoding and the prescaler width helper
//           shared by counter_ctrl and counter_prescaler.
// Contents: ST_IDLE/ST_RUN/ST_HOLD/ST_DONE (2-bit state codes, also driven
//           on the state output), MODE_ONESHOT/MODE_PERIODIC, presc_width().

package counter_pkg;

  // State codes are visible on the state output, so the values are fixed.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Bits needed to hold 0..n-1; never less than one so a PRESCALE of 1
  // still yields a legal (constant-zero) register.
  function automatic int presc_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - clock prescaler producing one tick every PRESCALE enabled cycles
//
// Purpose : divides enabled clock cycles down to count ticks for counter_ctrl.
// Ports   : clk    - rising-edge clock
//           reset  - synchronous active-high reset, phase back to 0
//           clear  - synchronous phase clear (start of a new run)
//           enable - advance the phase this cycle; low freezes it
//           tick   - combinational, high in the enabled cycle whose phase is PRESCALE-1

module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - programmable up-counter timer with start/stop/pause and prescaler
//
// Purpose : owns the count register and the IDLE/RUN/HOLD/DONE sequencer;
//           one-shot or periodic operation up to a latched terminal value.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           start, stop       - control strobes (stop has priority)
//           pause             - level, freezes counting while in RUN/HOLD
//           mode, limit       - operating mode and terminal value, latched at start
//           out               - registered count value
//           busy              - high in RUN and HOLD
//           wrap, done        - registered one-cycle event pulses
//           state             - current state code (see counter_pkg)

module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q,  mode_d;
  logic             wrap_q,  wrap_d;
  logic             done_q,  done_d;

  logic             launch;
  logic             presc_en;
  logic             tick;

  // The prescaler only advances in a RUN cycle that actually counts; the
  // cycle in which pause or stop is taken leaves its phase untouched so a
  // resumed run neither loses nor gains a count.
  assign presc_en = (state_q == ST_RUN) && !stop && !pause;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (presc_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    launch  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        out_d = '0;
        if (start) begin
          state_d = ST_RUN;
          limit_d = limit;
          mode_d  = mode;
          launch  = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (out_q != limit_q) begin
            out_d = out_q + WIDTH'(1);
          end else if (mode_q == MODE_PERIODIC) begin
            out_d  = '0;
            wrap_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end else if (start) begin
          state_d = ST_RUN;
          out_d   = '0;
          limit_d = limit;
          mode_d  = mode;
          launch  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign state = state_q;
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl at PRESCALE 1 and 3

module tb_counter_ctrl;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1 = 1'b1, start1 = 1'b0, stop1 = 1'b0, pause1 = 1'b0, mode1 = 1'b0;
  logic [2:0] limit1 = 3'd0;
  logic [2:0] out1;
  logic       busy1, wrap1, done1;
  logic [1:0] state1;

  logic       reset3 = 1'b1, start3 = 1'b0, stop3 = 1'b0, pause3 = 1'b0, mode3 = 1'b0;
  logic [2:0] limit3 = 3'd0;
  logic [2:0] out3;
  logic       busy3, wrap3, done3;
  logic [1:0] state3;

  counter_ctrl #(.WIDTH(3), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .stop(stop1), .pause(pause1),
    .mode(mode1), .limit(limit1), .out(out1), .busy(busy1), .wrap(wrap1),
    .done(done1), .state(state1)
  );

  counter_ctrl #(.WIDTH(3), .PRESCALE(3)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .stop(stop3), .pause(pause3),
    .mode(mode3), .limit(limit3), .out(out3), .busy(busy3), .wrap(wrap3),
    .done(done3), .state(state3)
  );

  typedef struct {
    int         dut;
    string      tag;
    logic [2:0] o;
    logic [1:0] s;
    logic       w;
    logic       d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: after each rising edge, pop the expectation queued for it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.dut == 1) begin
          check({mon_e.tag, ".out"},   32'(out1),   32'(mon_e.o));
          check({mon_e.tag, ".state"}, 32'(state1), 32'(mon_e.s));
          check({mon_e.tag, ".busy"},  32'(busy1),  32'(mon_e.s == ST_RUN || mon_e.s == ST_HOLD));
          check({mon_e.tag, ".wrap"},  32'(wrap1),  32'(mon_e.w));
          check({mon_e.tag, ".done"},  32'(done1),  32'(mon_e.d));
        end else begin
          check({mon_e.tag, ".out"},   32'(out3),   32'(mon_e.o));
          check({mon_e.tag, ".state"}, 32'(state3), 32'(mon_e.s));
          check({mon_e.tag, ".busy"},  32'(busy3),  32'(mon_e.s == ST_RUN || mon_e.s == ST_HOLD));
          check({mon_e.tag, ".wrap"},  32'(wrap3),  32'(mon_e.w));
          check({mon_e.tag, ".done"},  32'(done3),  32'(mon_e.d));
        end
      end
    end
  end

  // Inputs are already set by the caller; queue what must appear after the next edge.
  task automatic cyc(input int d, input string tag, input logic [2:0] o,
                     input logic [1:0] s, input logic w, input logic dn);
    exp_t e;
    e.dut = d; e.tag = tag; e.o = o; e.s = s; e.w = w; e.d = dn;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset and idle
    cyc(1, "reset", 3'd0, ST_IDLE, 1'b0, 1'b0);
    reset1 = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, $sformatf("idle%0d", i), 3'd0, ST_IDLE, 1'b0, 1'b0);

    // Periodic, limit 7; input changes after start and a start while running are ignored
    start1 = 1'b1; mode1 = 1'b1; limit1 = 3'd7;
    cyc(1, "p_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0; limit1 = 3'd2; mode1 = 1'b0;
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 1; i <= 7; i++) begin
        if (lap == 1 && i == 3) begin
          start1 = 1'b1; limit1 = 3'd3;
        end
        cyc(1, $sformatf("p_cnt%0d_%0d", lap, i), 3'(i), ST_RUN, 1'b0, 1'b0);
        start1 = 1'b0;
      end
      cyc(1, $sformatf("p_wrap%0d", lap), 3'd0, ST_RUN, 1'b1, 1'b0);
    end
    stop1 = 1'b1;
    cyc(1, "p_stop", 3'd0, ST_IDLE, 1'b0, 1'b0);
    stop1 = 1'b0;

    // One-shot, limit 4, then restart from DONE
    start1 = 1'b1; mode1 = 1'b0; limit1 = 3'd4;
    cyc(1, "os_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0;
    for (int i = 1; i <= 4; i++) cyc(1, $sformatf("os_cnt%0d", i), 3'(i), ST_RUN, 1'b0, 1'b0);
    cyc(1, "os_done", 3'd4, ST_DONE, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1, $sformatf("os_hold%0d", i), 3'd4, ST_DONE, 1'b0, 1'b0);
    start1 = 1'b1;
    cyc(1, "os_restart", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0;
    cyc(1, "os_recnt", 3'd1, ST_RUN, 1'b0, 1'b0);
    stop1 = 1'b1;
    cyc(1, "os_stop", 3'd0, ST_IDLE, 1'b0, 1'b0);
    stop1 = 1'b0;

    // One-shot with limit 0: done on first tick; stop from DONE
    start1 = 1'b1; mode1 = 1'b0; limit1 = 3'd0;
    cyc(1, "os0_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0;
    cyc(1, "os0_done", 3'd0, ST_DONE, 1'b0, 1'b1);
    stop1 = 1'b1;
    cyc(1, "os0_stop", 3'd0, ST_IDLE, 1'b0, 1'b0);
    stop1 = 1'b0;

    // Pause at out=3 for four cycles, then resume without lost counts
    start1 = 1'b1; mode1 = 1'b1; limit1 = 3'd7;
    cyc(1, "pz_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1, $sformatf("pz_cnt%0d", i), 3'(i), ST_RUN, 1'b0, 1'b0);
    pause1 = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, $sformatf("pz_hold%0d", i), 3'd3, ST_HOLD, 1'b0, 1'b0);
    pause1 = 1'b0;
    cyc(1, "pz_resume", 3'd3, ST_RUN, 1'b0, 1'b0);
    cyc(1, "pz_cnt4", 3'd4, ST_RUN, 1'b0, 1'b0);
    cyc(1, "pz_cnt5", 3'd5, ST_RUN, 1'b0, 1'b0);

    // Stop and start together at out=5
    stop1 = 1'b1; start1 = 1'b1;
    cyc(1, "stop_start", 3'd0, ST_IDLE, 1'b0, 1'b0);
    stop1 = 1'b0; start1 = 1'b0;

    // Reset mid-run at out=5
    start1 = 1'b1;
    cyc(1, "rs_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start1 = 1'b0;
    for (int i = 1; i <= 5; i++) cyc(1, $sformatf("rs_cnt%0d", i), 3'(i), ST_RUN, 1'b0, 1'b0);
    reset1 = 1'b1;
    cyc(1, "reset_mid", 3'd0, ST_IDLE, 1'b0, 1'b0);
    reset1 = 1'b0;
    cyc(1, "reset_idle", 3'd0, ST_IDLE, 1'b0, 1'b0);

    // PRESCALE=3 instance: periodic limit 2
    cyc(3, "r3", 3'd0, ST_IDLE, 1'b0, 1'b0);
    reset3 = 1'b0;
    start3 = 1'b1; mode3 = 1'b1; limit3 = 3'd2;
    cyc(3, "p3_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start3 = 1'b0;
    for (int lap = 0; lap < 2; lap++) begin
      for (int v = 0; v < 3; v++) begin
        for (int k = 0; k < 3; k++) begin
          if (!(lap == 0 && v == 0 && k == 0)) begin
            cyc(3, $sformatf("p3_%0d_%0d_%0d", lap, v, k), 3'(v), ST_RUN,
                1'(v == 0 && k == 0), 1'b0);
          end
        end
      end
    end
    cyc(3, "p3_wrap", 3'd0, ST_RUN, 1'b1, 1'b0);
    stop3 = 1'b1;
    cyc(3, "p3_stop", 3'd0, ST_IDLE, 1'b0, 1'b0);
    stop3 = 1'b0;

    // PRESCALE=3, limit 0 periodic: wrap every third cycle, out stays 0
    start3 = 1'b1; mode3 = 1'b1; limit3 = 3'd0;
    cyc(3, "z3_start", 3'd0, ST_RUN, 1'b0, 1'b0);
    start3 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cyc(3, $sformatf("z3_a%0d", r), 3'd0, ST_RUN, 1'b0, 1'b0);
      cyc(3, $sformatf("z3_b%0d", r), 3'd0, ST_RUN, 1'b0, 1'b0);
      cyc(3, $sformatf("z3_w%0d", r), 3'd0, ST_RUN, 1'b1, 1'b0);
    end

    @(posedge clk);
    #4;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
